tag_window_counter: RTL and testbench
=====================================

Name: tag_window_counter

Overview:
- Downstream consumer of the time-tag AXI stream (axis_tag_interface, WORD_WIDTH lanes per beat).
- Counts rising-edge tags per channel over consecutive fixed-length windows in ps.
- Emits one count vector per window on a valid/ready output.
- Used as the histogram/count-rate front end behind the tag source and any tag filters.

Parameters:
- NUM_CHANNELS, 8, channels counted; channel indices 1..NUM_CHANNELS.
- COUNT_WIDTH, 32, per-channel counter width.
- WINDOW_WIDTH, 48, width of window_length_ps.

Ports:
- clk  input  1  single clock for all logic; must equal s_time.clk.
- rst_n  input  1  asynchronous active-low reset; s_time.rst is ignored.
- s_time  axis_tag_interface.slave  -  tag stream: tvalid, tready, tkeep, tagtime, channel, lowest_time_bound.
- start  input  1  one-cycle pulse; honoured in IDLE only.
- stop  input  1  one-cycle pulse; return to IDLE after the current window is emitted.
- window_length_ps  input  WINDOW_WIDTH  window length; sampled on accepted start.
- m_valid  output  1  count vector valid.
- m_ready  input  1  downstream accept.
- m_counts  output  NUM_CHANNELS*COUNT_WIDTH  channel k count at bits [(k-1)*COUNT_WIDTH +: COUNT_WIDTH].
- m_window_start  output  s_time.TIME_WIDTH  start time (ps) of the emitted window.
- m_overflow  output  1  at least one counter saturated in this window.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; m_valid=0; m_counts=0; m_overflow=0; m_window_start=0; busy=0.
  - All counters, lane-consumed mask and stop_pending cleared.
- Time compare: tagtime vs window_end, unsigned, TIME_WIDTH bits; no wrap handling.
- window_end = window_start + window_length_ps, zero-extended.
- Only lanes with tkeep=1 are considered.
- IDLE:
  - s_time.tready=1; all tags discarded.
  - start with window_length_ps!=0 -> latch length, go ARM.
  - start with window_length_ps==0 -> ignored; stay IDLE.
- ARM:
  - tready=0.
  - On tvalid with any kept lane: window_start = tagtime of lowest-index kept lane; go COUNT. That beat is not consumed yet.
  - Beat with tvalid=1, tkeep=0: consumed (tready=1), stay ARM.
- COUNT:
  - Eligible lane: kept, not yet consumed, tagtime < window_end.
  - Pending lane: kept, not yet consumed, tagtime >= window_end.
  - Each eligible lane with channel in 1..NUM_CHANNELS increments its counter. Multiple lanes per beat sum correctly. Counters saturate at all-ones and set the sticky overflow flag.
  - Lanes with other channel codes are consumed and not counted.
  - No pending lane -> tready=1; beat accepted; consumed mask cleared.
  - Any pending lane -> tready=0; eligible lanes marked consumed; go EMIT next cycle.
  - tvalid=0 or all lanes consumed, and lowest_time_bound >= window_end -> go EMIT; this closes empty windows.
- EMIT:
  - On entry, register counters -> m_counts, window_start -> m_window_start, overflow -> m_overflow; m_valid=1.
  - tready=0.
  - m_valid, m_counts, m_window_start and m_overflow are held stable until m_valid && m_ready.
  - On handshake: counters and overflow cleared; window_start += length.
  - Then go IDLE if stop_pending, else COUNT.
- stop received in ARM/COUNT sets stop_pending; ARM+stop -> IDLE immediately. stop in IDLE is ignored.
- start outside IDLE is ignored.
- Latency: window closure detected in cycle N -> m_valid=1 in cycle N+1.
- No tag is ever counted in two windows.
- Reset mid-window: the partial window is lost; no emission.

Optional Feature:
- Macro: TAG_WINDOW_COUNTER_FALLING_EN.
- Defined: falling-edge tags with channel == 2**CHANNEL_WIDTH - k, k in 1..NUM_CHANNELS, are also counted into counter k.
- Undefined: falling-edge tags are consumed and ignored.

Test Plan:
- Single window: length=1000, tags ch1 @100, @200, ch2 @500 (first tag sets start=100), bound advances to 1200 -> m_counts ch1=2, ch2=1, others 0; m_window_start=100.
- Straddling beat:
  - length=1000, one beat with ch3 @0, @999, @1000, @2500; bound to 4000.
  - Expected windows [0,1000) ch3=2; [1000,2000) ch3=1; [2000,3000) ch3=1; [3000,4000) ch3=0.
  - tready held low until the last lane is eligible.
- Backpressure: hold m_ready=0 for 20 cycles during EMIT -> m_valid and m_counts stable; s_time.tready=0 throughout; no tags lost; all tag counts appear in later windows.
- Saturation: COUNT_WIDTH=4, 17 ch1 tags in one window -> ch1=15, m_overflow=1; next window m_overflow=0.
- Reset and stop:
  - rst_n low mid-COUNT -> m_valid=0 immediately (async); busy=0 and no emission.
  - stop in COUNT -> exactly one more emission, then IDLE with tready=1.
  - start with length=0 -> busy stays 0.
- Falling edges: ch1 falling tags with TAG_WINDOW_COUNTER_FALLING_EN defined -> counted in ch1; with it undefined -> ch1=0.

Source files
------------

// File: rtl/tag_window_counter_if.sv
// Time-tag AXI stream: WORD_WIDTH lanes per beat, each with a tag time and a channel code.
interface axis_tag_interface #(
  parameter int unsigned WORD_WIDTH    = 4,
  parameter int unsigned TIME_WIDTH    = 64,
  parameter int unsigned CHANNEL_WIDTH = 6
) (
  input logic clk,
  input logic rst
);
  logic                                     tvalid;
  logic                                     tready;
  logic [WORD_WIDTH-1:0]                    tkeep;
  logic [WORD_WIDTH-1:0][TIME_WIDTH-1:0]    tagtime;
  logic [WORD_WIDTH-1:0][CHANNEL_WIDTH-1:0] channel;
  logic [TIME_WIDTH-1:0]                    lowest_time_bound;

  modport master (input clk, rst, tready,
                  output tvalid, tkeep, tagtime, channel, lowest_time_bound);
  modport slave  (input clk, rst, tvalid, tkeep, tagtime, channel, lowest_time_bound,
                  output tready);
endinterface

// File: rtl/tag_window_counter.sv
// Per-channel tag counter over consecutive fixed-length windows, one count vector per window.
// TAG_WINDOW_COUNTER_FALLING_EN: also count falling-edge codes 2**CHANNEL_WIDTH-k into counter k.
module tag_window_counter #(
  parameter int unsigned NUM_CHANNELS  = 8,
  parameter int unsigned COUNT_WIDTH   = 32,
  parameter int unsigned WINDOW_WIDTH  = 48,
  // Must match the parameters of the connected s_time interface.
  parameter int unsigned WORD_WIDTH    = 4,
  parameter int unsigned TIME_WIDTH    = 64,
  parameter int unsigned CHANNEL_WIDTH = 6
) (
  input  logic                                clk,
  input  logic                                rst_n,
  axis_tag_interface.slave                    s_time,
  input  logic                                start,
  input  logic                                stop,
  input  logic [WINDOW_WIDTH-1:0]             window_length_ps,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [NUM_CHANNELS*COUNT_WIDTH-1:0] m_counts,
  output logic [TIME_WIDTH-1:0]               m_window_start,
  output logic                                m_overflow,
  output logic                                busy
);
  localparam int unsigned IW = $clog2(WORD_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ARM, COUNT, EMIT} state_e;

  state_e                                     state_q;
  logic [WINDOW_WIDTH-1:0]                    len_q;
  logic [TIME_WIDTH-1:0]                      win_start_q;
  logic [NUM_CHANNELS-1:0][COUNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                                       ovf_q, ovf_d;
  logic [WORD_WIDTH-1:0]                      consumed_q;
  logic                                       stop_pend_q;

  logic [TIME_WIDTH-1:0] win_end, first_time;
  logic [WORD_WIDTH-1:0] live, elig;
  logic                  any_live, any_pend, found, close_win;
  logic [IW-1:0]         inc;
  logic                  sat;

  function automatic logic chan_hit(input logic [CHANNEL_WIDTH-1:0] ch, input int unsigned k);
    logic hit;
    hit = (ch == CHANNEL_WIDTH'(k + 1));
`ifdef TAG_WINDOW_COUNTER_FALLING_EN
    hit = hit | (ch == CHANNEL_WIDTH'((1 << CHANNEL_WIDTH) - k - 1));
`endif
    return hit;
  endfunction

  // Returns {saturated, value}; an overflowing sum clamps to all-ones.
  function automatic logic [COUNT_WIDTH:0] sat_add(input logic [COUNT_WIDTH-1:0] a,
                                                   input logic [IW-1:0] b);
    logic [COUNT_WIDTH:0] s;
    s = {1'b0, a} + (COUNT_WIDTH + 1)'(b);
    return s[COUNT_WIDTH] ? '1 : s;
  endfunction

  always_comb begin
    win_end    = win_start_q + TIME_WIDTH'(len_q);
    live       = '0;
    elig       = '0;
    first_time = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
      if (s_time.tkeep[i] && !found) begin
        first_time = s_time.tagtime[i];
        found      = 1'b1;
      end
      live[i] = s_time.tvalid & s_time.tkeep[i] & ~consumed_q[i];
      elig[i] = live[i] & (s_time.tagtime[i] < win_end);
    end
    any_live  = |live;
    any_pend  = |(live & ~elig);
    close_win = any_pend || (!any_live && (s_time.lowest_time_bound >= win_end));

    ovf_d = ovf_q;
    cnt_d = cnt_q;
    inc   = '0;
    sat   = 1'b0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      inc = '0;
      for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
        if (elig[i] && chan_hit(s_time.channel[i], k)) inc = inc + IW'(1);
      end
      {sat, cnt_d[k]} = sat_add(cnt_q[k], inc);
      ovf_d = ovf_d | sat;
    end
  end

  always_comb begin
    unique case (state_q)
      IDLE:    s_time.tready = 1'b1;
      ARM:     s_time.tready = s_time.tvalid & ~|s_time.tkeep;
      COUNT:   s_time.tready = ~any_pend;
      default: s_time.tready = 1'b0;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      len_q          <= '0;
      win_start_q    <= '0;
      cnt_q          <= '0;
      ovf_q          <= 1'b0;
      consumed_q     <= '0;
      stop_pend_q    <= 1'b0;
      m_valid        <= 1'b0;
      m_counts       <= '0;
      m_window_start <= '0;
      m_overflow     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          consumed_q  <= '0;
          stop_pend_q <= 1'b0;
          if (start && (window_length_ps != '0)) begin
            len_q   <= window_length_ps;
            state_q <= ARM;
          end
        end
        ARM: begin
          if (stop) begin
            state_q <= IDLE;
          end else if (s_time.tvalid && |s_time.tkeep) begin
            win_start_q <= first_time;
            state_q     <= COUNT;
          end
        end
        COUNT: begin
          if (stop) stop_pend_q <= 1'b1;
          cnt_q <= cnt_d;
          ovf_q <= ovf_d;
          // A beat with pending lanes stays on the bus; only its counted lanes are masked off.
          if (any_pend)           consumed_q <= consumed_q | elig;
          else if (s_time.tvalid) consumed_q <= '0;
          if (close_win) begin
            state_q        <= EMIT;
            m_valid        <= 1'b1;
            m_counts       <= cnt_d;
            m_overflow     <= ovf_d;
            m_window_start <= win_start_q;
          end
        end
        EMIT: begin
          if (stop) stop_pend_q <= 1'b1;
          if (m_ready) begin
            m_valid     <= 1'b0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            win_start_q <= win_end;
            if (stop_pend_q || stop) begin
              state_q     <= IDLE;
              stop_pend_q <= 1'b0;
            end else begin
              state_q <= COUNT;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tag_window_counter.sv
// Directed bench for tag_window_counter with 4 channels, 4-bit counters and 4 lanes per beat.
module tb_tag_window_counter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] window_length_ps = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [15:0] m_counts;
  logic [31:0] m_window_start;
  logic        m_overflow;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] counts;
    logic [31:0] wstart;
    logic        ovf;
  } emit_t;
  emit_t emits[$];

  axis_tag_interface #(.WORD_WIDTH(4), .TIME_WIDTH(32), .CHANNEL_WIDTH(4)) s_bus (
    .clk(clk),
    .rst(!rst_n)
  );

  tag_window_counter #(
    .NUM_CHANNELS(4), .COUNT_WIDTH(4), .WINDOW_WIDTH(32),
    .WORD_WIDTH(4), .TIME_WIDTH(32), .CHANNEL_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_time(s_bus), .start(start), .stop(stop),
    .window_length_ps(window_length_ps), .m_valid(m_valid), .m_ready(m_ready),
    .m_counts(m_counts), .m_window_start(m_window_start), .m_overflow(m_overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && m_valid && m_ready) emits.push_back('{m_counts, m_window_start, m_overflow});

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    s_bus.tvalid = 1'b0;
    s_bus.tkeep = '0;
    s_bus.lowest_time_bound = '0;
    m_ready = 1'b1;
    cycles(2);
    rst_n = 1'b1;
    emits.delete();
    cycles(1);
  endtask

  task automatic start_run(input logic [31:0] len);
    window_length_ps = len;
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
  endtask

  task automatic send_beat(input string tag, input logic [3:0] keep,
                           input logic [31:0] t0, t1, t2, t3,
                           input logic [3:0] c0, c1, c2, c3);
    int n = 0;
    s_bus.tkeep = keep;
    s_bus.tagtime[0] = t0; s_bus.tagtime[1] = t1; s_bus.tagtime[2] = t2; s_bus.tagtime[3] = t3;
    s_bus.channel[0] = c0; s_bus.channel[1] = c1; s_bus.channel[2] = c2; s_bus.channel[3] = c3;
    s_bus.tvalid = 1'b1;
    @(negedge clk);
    while (!s_bus.tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check({tag, "_tready_timeout"}, 64'(n), 64'(0));
    @(posedge clk); #1;
    s_bus.tvalid = 1'b0;
    s_bus.tkeep = '0;
  endtask

  task automatic wait_emits(input string tag, input int n);
    int k = 0;
    while (emits.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_emit_count"}, 64'(emits.size()), 64'(n));
    cycles(1);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    @(negedge clk);
    while (!m_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid_seen"}, 64'(m_valid), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] fall_exp;
    s_bus.tvalid = 1'b0;
    s_bus.tkeep = '0;
    s_bus.tagtime = '0;
    s_bus.channel = '0;
    s_bus.lowest_time_bound = '0;
    cycles(2);

    // Reset state
    #1;
    check("rst_valid", 64'(m_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_counts", 64'(m_counts), 64'(0));
    check("rst_wstart", 64'(m_window_start), 64'(0));
    check("rst_ovf", 64'(m_overflow), 64'(0));
    rst_n = 1'b1;
    cycles(1);
    check("idle_tready", 64'(s_bus.tready), 64'(1));

    // Zero-length start is ignored
    start_run(32'd0);
    cycles(1);
    check("len0_busy", 64'(busy), 64'(0));

    // Single window, then stop -> one more (empty) emission and IDLE
    start_run(32'd1000);
    check("single_busy", 64'(busy), 64'(1));
    send_beat("single", 4'b0111, 32'd100, 32'd200, 32'd500, 32'd0, 4'd1, 4'd1, 4'd2, 4'd0);
    s_bus.lowest_time_bound = 32'd1200;
    wait_emits("single", 1);
    check("single_counts", 64'(emits[0].counts), 64'h0012);
    check("single_wstart", 64'(emits[0].wstart), 64'd100);
    check("single_ovf", 64'(emits[0].ovf), 64'd0);
    pulse_stop();
    s_bus.lowest_time_bound = 32'd2100;
    wait_emits("stop", 2);
    check("stop_counts", 64'(emits[1].counts), 64'h0000);
    check("stop_wstart", 64'(emits[1].wstart), 64'd1100);
    cycles(5);
    check("stop_busy", 64'(busy), 64'(0));
    check("stop_tready", 64'(s_bus.tready), 64'(1));
    check("stop_no_extra", 64'(emits.size()), 64'd2);

    // One beat straddling four windows
    do_reset();
    start_run(32'd1000);
    send_beat("strad", 4'b1111, 32'd0, 32'd999, 32'd1000, 32'd2500, 4'd3, 4'd3, 4'd3, 4'd3);
    check("strad_held_low", 64'(emits.size()), 64'd2);
    s_bus.lowest_time_bound = 32'd4000;
    wait_emits("strad", 4);
    check("strad_w0", {emits[0].wstart, 16'h0, emits[0].counts}, {32'd0, 16'h0, 16'h0200});
    check("strad_w1", {emits[1].wstart, 16'h0, emits[1].counts}, {32'd1000, 16'h0, 16'h0100});
    check("strad_w2", {emits[2].wstart, 16'h0, emits[2].counts}, {32'd2000, 16'h0, 16'h0100});
    check("strad_w3", {emits[3].wstart, 16'h0, emits[3].counts}, {32'd3000, 16'h0, 16'h0000});

    // Backpressure during EMIT, then reset with an emission pending
    do_reset();
    start_run(32'd100);
    m_ready = 1'b0;
    send_beat("bp", 4'b0011, 32'd10, 32'd20, 32'd0, 32'd0, 4'd1, 4'd2, 4'd0, 4'd0);
    s_bus.lowest_time_bound = 32'd200;
    wait_valid("bp");
    s_bus.tkeep = 4'b0001;
    s_bus.tagtime[0] = 32'd150;
    s_bus.channel[0] = 4'd4;
    s_bus.tvalid = 1'b1;
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(m_valid), 64'd1);
      check("bp_counts", 64'(m_counts), 64'h0011);
      check("bp_tready", 64'(s_bus.tready), 64'd0);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    begin
      int n = 0;
      @(negedge clk);
      while (!s_bus.tready && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("bp_resume_tready", 64'(s_bus.tready), 64'd1);
    end
    @(posedge clk); #1;
    s_bus.tvalid = 1'b0;
    s_bus.tkeep = '0;
    s_bus.lowest_time_bound = 32'd300;
    wait_emits("bp", 2);
    check("bp_w0", {emits[0].wstart, 16'h0, emits[0].counts}, {32'd10, 16'h0, 16'h0011});
    check("bp_w1", {emits[1].wstart, 16'h0, emits[1].counts}, {32'd110, 16'h0, 16'h1000});
    m_ready = 1'b0;
    s_bus.lowest_time_bound = 32'd400;
    wait_valid("rstmid");
    #3 rst_n = 1'b0;
    #1;
    check("rstmid_valid", 64'(m_valid), 64'd0);
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_counts", 64'(m_counts), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_bus.lowest_time_bound = '0;
    m_ready = 1'b1;
    cycles(5);
    check("rstmid_no_emit", 64'(emits.size()), 64'd2);

    // Saturation of a 4-bit counter with 17 tags
    do_reset();
    start_run(32'd1000);
    send_beat("sat", 4'b1111, 32'd1, 32'd2, 32'd3, 32'd4, 4'd1, 4'd1, 4'd1, 4'd1);
    send_beat("sat", 4'b1111, 32'd5, 32'd6, 32'd7, 32'd8, 4'd1, 4'd1, 4'd1, 4'd1);
    send_beat("sat", 4'b1111, 32'd9, 32'd10, 32'd11, 32'd12, 4'd1, 4'd1, 4'd1, 4'd1);
    send_beat("sat", 4'b1111, 32'd13, 32'd14, 32'd15, 32'd16, 4'd1, 4'd1, 4'd1, 4'd1);
    send_beat("sat", 4'b0001, 32'd17, 32'd0, 32'd0, 32'd0, 4'd1, 4'd0, 4'd0, 4'd0);
    s_bus.lowest_time_bound = 32'd1100;
    wait_emits("sat", 1);
    check("sat_counts", 64'(emits[0].counts), 64'h000F);
    check("sat_ovf", 64'(emits[0].ovf), 64'd1);
    send_beat("sat2", 4'b0001, 32'd1500, 32'd0, 32'd0, 32'd0, 4'd1, 4'd0, 4'd0, 4'd0);
    s_bus.lowest_time_bound = 32'd2100;
    wait_emits("sat2", 2);
    check("sat2_counts", 64'(emits[1].counts), 64'h0001);
    check("sat2_ovf", 64'(emits[1].ovf), 64'd0);
    check("sat2_wstart", 64'(emits[1].wstart), 64'd1001);

    // Falling-edge codes (15 = falling ch1) and an uncounted code 0
    do_reset();
    start_run(32'd1000);
    send_beat("fall", 4'b1111, 32'd5, 32'd6, 32'd7, 32'd8, 4'd15, 4'd15, 4'd1, 4'd0);
    s_bus.lowest_time_bound = 32'd2000;
    wait_emits("fall", 1);
`ifdef TAG_WINDOW_COUNTER_FALLING_EN
    fall_exp = 16'h0003;
`else
    fall_exp = 16'h0001;
`endif
    check("fall_counts", 64'(emits[0].counts), 64'(fall_exp));
    check("fall_wstart", 64'(emits[0].wstart), 64'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
